render_frame_ctrl: RTL and testbench

Per-frame sequencer for the rasterizer back end. On each frame start it clears the framebuffer and depth buffer through a dedicated clear write port. It then issues the frame's triangles to the rasterizer one at a time using a start/done handshake. It finishes with a single-cycle buffer-swap pulse. It runs in the render clock domain, between the display `frame` pulse (synchronised upstream) and the rasterizer and buffer write ports.

---
 rtl/render_frame_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_render_frame_ctrl.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/render_frame_ctrl.sv
// rtl/render_frame_ctrl.sv - per-frame sequencer: buffer clear, triangle issue, swap pulse
// Optional WAIT watchdog and tri_timeout port enabled by defining CTRL_TIMEOUT_EN.
module render_frame_ctrl #(
   parameter int FB_PIXELS      = 19200,
   parameter int FB_ADDRW       = 15,
   parameter int FB_DATAW       = 4,
   parameter int DB_DATAW       = 12,
   parameter int CLEAR_COLR     = 0,
   parameter int DB_CLEAR_VALUE = 4095,
   parameter int TRI_CNTW       = 8,
   parameter int TIMEOUT_CYCLES = 65535
) (
   input  logic                clk,
   input  logic                rstn,
   input  logic                frame_start,
   input  logic [TRI_CNTW-1:0] num_triangles,
   output logic [FB_ADDRW-1:0] clear_addr,
   output logic                clear_we,
   output logic [FB_DATAW-1:0] clear_colr,
   output logic [DB_DATAW-1:0] clear_depth,
   output logic [TRI_CNTW-1:0] tri_idx,
   output logic                tri_start,
   input  logic                tri_done,
   output logic                swap,
   output logic                busy,
   output logic                frame_overrun
`ifdef CTRL_TIMEOUT_EN
   ,
   output logic                tri_timeout
`endif
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_ISSUE,
      S_WAIT,
      S_SWAP
   } state_t;

   localparam logic [FB_ADDRW-1:0] LAST_ADDR = FB_ADDRW'(FB_PIXELS - 1);

   if (FB_PIXELS < 1 || FB_PIXELS > (1 << FB_ADDRW) || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
      $error("render_frame_ctrl: invalid parameter set");
   end

   state_t              state_q, state_d;
   logic [FB_ADDRW-1:0] clear_addr_q, clear_addr_d;
   logic                clear_we_q, clear_we_d;
   logic [TRI_CNTW-1:0] tri_idx_q, tri_idx_d;
   logic                tri_start_q, tri_start_d;
   logic                swap_q, swap_d;
   logic                busy_q, busy_d;
   logic                frame_overrun_q, frame_overrun_d;
   logic [TRI_CNTW-1:0] n_lat_q, n_lat_d;
   logic                advance;

`ifdef CTRL_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

   logic [TO_W-1:0] to_cnt_q, to_cnt_d;
   logic            tri_timeout_q, tri_timeout_d;
   logic            to_hit;

   // A timeout counts as a completion only when the real done did not arrive.
   assign to_hit  = (state_q == S_WAIT) && (to_cnt_q == TO_LAST) && !tri_done;
   assign advance = tri_done || to_hit;
`else
   assign advance = tri_done;
`endif

   always_comb begin
      state_d         = state_q;
      clear_addr_d    = clear_addr_q;
      clear_we_d      = 1'b0;
      tri_idx_d       = tri_idx_q;
      tri_start_d     = 1'b0;
      swap_d          = 1'b0;
      n_lat_d         = n_lat_q;
      frame_overrun_d = frame_start && (state_q != S_IDLE);
`ifdef CTRL_TIMEOUT_EN
      to_cnt_d        = to_cnt_q;
      tri_timeout_d   = 1'b0;
`endif

      case (state_q)
         S_IDLE: begin
            if (frame_start) begin
               n_lat_d      = num_triangles;
               state_d      = S_CLEAR;
               clear_we_d   = 1'b1;
               clear_addr_d = '0;
            end
         end
         S_CLEAR: begin
            // clear_we_q low here means the last address was written last cycle.
            if (clear_we_q) begin
               if (clear_addr_q == LAST_ADDR) begin
                  clear_addr_d = '0;
               end else begin
                  clear_addr_d = clear_addr_q + 1'b1;
                  clear_we_d   = 1'b1;
               end
            end else if (n_lat_q == '0) begin
               state_d = S_SWAP;
               swap_d  = 1'b1;
            end else begin
               state_d     = S_ISSUE;
               tri_idx_d   = '0;
               tri_start_d = 1'b1;
`ifdef CTRL_TIMEOUT_EN
               to_cnt_d    = '0;
`endif
            end
         end
         S_ISSUE: begin
            state_d = S_WAIT;
         end
         S_WAIT: begin
`ifdef CTRL_TIMEOUT_EN
            to_cnt_d      = to_cnt_q + 1'b1;
            tri_timeout_d = to_hit;
`endif
            if (advance) begin
               if (tri_idx_q == n_lat_q - 1'b1) begin
                  state_d = S_SWAP;
                  swap_d  = 1'b1;
               end else begin
                  state_d     = S_ISSUE;
                  tri_idx_d   = tri_idx_q + 1'b1;
                  tri_start_d = 1'b1;
`ifdef CTRL_TIMEOUT_EN
                  to_cnt_d    = '0;
`endif
               end
            end
         end
         S_SWAP: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q         <= S_IDLE;
         clear_addr_q    <= '0;
         clear_we_q      <= 1'b0;
         tri_idx_q       <= '0;
         tri_start_q     <= 1'b0;
         swap_q          <= 1'b0;
         busy_q          <= 1'b0;
         frame_overrun_q <= 1'b0;
         n_lat_q         <= '0;
`ifdef CTRL_TIMEOUT_EN
         to_cnt_q        <= '0;
         tri_timeout_q   <= 1'b0;
`endif
      end else begin
         state_q         <= state_d;
         clear_addr_q    <= clear_addr_d;
         clear_we_q      <= clear_we_d;
         tri_idx_q       <= tri_idx_d;
         tri_start_q     <= tri_start_d;
         swap_q          <= swap_d;
         busy_q          <= busy_d;
         frame_overrun_q <= frame_overrun_d;
         n_lat_q         <= n_lat_d;
`ifdef CTRL_TIMEOUT_EN
         to_cnt_q        <= to_cnt_d;
         tri_timeout_q   <= tri_timeout_d;
`endif
      end
   end

   assign clear_addr    = clear_addr_q;
   assign clear_we      = clear_we_q;
   assign clear_colr    = FB_DATAW'(CLEAR_COLR);
   assign clear_depth   = DB_DATAW'(DB_CLEAR_VALUE);
   assign tri_idx       = tri_idx_q;
   assign tri_start     = tri_start_q;
   assign swap          = swap_q;
   assign busy          = busy_q;
   assign frame_overrun = frame_overrun_q;
`ifdef CTRL_TIMEOUT_EN
   assign tri_timeout   = tri_timeout_q;
`endif

endmodule

// File: tb/tb_render_frame_ctrl.sv
// tb/tb_render_frame_ctrl.sv - directed self-checking bench for render_frame_ctrl (FB_PIXELS=16)
module tb_render_frame_ctrl;

   localparam int FBP  = 16;
   localparam int AW   = 5;
   localparam int TCW  = 8;

   logic           clk = 1'b0;
   logic           rstn = 1'b0;
   logic           frame_start = 1'b0;
   logic [TCW-1:0] num_triangles = '0;
   logic [AW-1:0]  clear_addr;
   logic           clear_we;
   logic [3:0]     clear_colr;
   logic [11:0]    clear_depth;
   logic [TCW-1:0] tri_idx;
   logic           tri_start;
   logic           tri_done;
   logic           swap;
   logic           busy;
   logic           frame_overrun;
`ifdef CTRL_TIMEOUT_EN
   logic           tri_timeout;
`endif

   logic rast_done = 1'b0;
   logic inj_done  = 1'b0;
   assign tri_done = rast_done | inj_done;

   render_frame_ctrl #(
      .FB_PIXELS(FBP), .FB_ADDRW(AW), .FB_DATAW(4), .DB_DATAW(12),
      .CLEAR_COLR(0), .DB_CLEAR_VALUE(4095), .TRI_CNTW(TCW), .TIMEOUT_CYCLES(20)
   ) dut (
      .clk(clk), .rstn(rstn), .frame_start(frame_start), .num_triangles(num_triangles),
      .clear_addr(clear_addr), .clear_we(clear_we), .clear_colr(clear_colr),
      .clear_depth(clear_depth), .tri_idx(tri_idx), .tri_start(tri_start),
      .tri_done(tri_done), .swap(swap), .busy(busy), .frame_overrun(frame_overrun)
`ifdef CTRL_TIMEOUT_EN
      , .tri_timeout(tri_timeout)
`endif
   );

   always #5 clk = ~clk;

   int cyc  = 0;
   int base = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp = 0;
   int n_bad = 0;

   // Monitor / rasterizer model state; cycle numbers are relative to base.
   logic clr_req  = 1'b0;
   logic rast_en  = 1'b0;
   logic drop1    = 1'b0;
   int   we_first, we_last, we_n, addr_err, st_n, sw_n, sw_cyc, ov_n, busy_last, cd;
   int   to_n, to_cyc;
   int   st_cyc [8];
   int   st_idx [8];

   always @(negedge clk) begin
      int c;
      c = cyc + 1 - base;
      if (clr_req) begin
         we_first = 0; we_last = 0; we_n = 0; addr_err = 0; st_n = 0;
         sw_n = 0; sw_cyc = 0; ov_n = 0; busy_last = 0; cd = 0; to_n = 0; to_cyc = 0;
         for (int i = 0; i < 8; i++) begin
            st_cyc[i] = 0;
            st_idx[i] = 0;
         end
      end
      rast_done = 1'b0;
      if (cd > 0) begin
         cd = cd - 1;
         if (cd == 0) rast_done = 1'b1;
      end
      if (clear_we) begin
         if (we_n == 0) we_first = c;
         we_last = c;
         if (32'(clear_addr) != we_n) addr_err = addr_err + 1;
         we_n = we_n + 1;
      end
      if (tri_start) begin
         if (st_n < 8) begin
            st_cyc[st_n] = c;
            st_idx[st_n] = 32'(tri_idx);
         end
         st_n = st_n + 1;
         if (rast_en && !(drop1 && tri_idx == 8'd1)) cd = 5;
      end
      if (swap) begin
         sw_n   = sw_n + 1;
         sw_cyc = c;
      end
      if (frame_overrun) ov_n = ov_n + 1;
      if (busy) busy_last = c;
`ifdef CTRL_TIMEOUT_EN
      if (tri_timeout) begin
         to_n   = to_n + 1;
         to_cyc = c;
      end
`endif
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic begin_test();
      clr_req = 1'b1;
      @(negedge clk);
      @(negedge clk);
      clr_req = 1'b0;
      base = cyc;
   endtask

   task automatic wait_rel(input int e);
      while (cyc - base < e) @(negedge clk);
   endtask

   task automatic fs_at(input int e);
      wait_rel(e - 1);
      frame_start = 1'b1;
      @(negedge clk);
      frame_start = 1'b0;
   endtask

   task automatic inj_at(input int e);
      wait_rel(e - 1);
      inj_done = 1'b1;
      @(negedge clk);
      inj_done = 1'b0;
   endtask

   task automatic chk_reset(input string pfx);
      check({pfx, "_we"},    32'(clear_we), 0);
      check({pfx, "_addr"},  32'(clear_addr), 0);
      check({pfx, "_idx"},   32'(tri_idx), 0);
      check({pfx, "_start"}, 32'(tri_start), 0);
      check({pfx, "_swap"},  32'(swap), 0);
      check({pfx, "_busy"},  32'(busy), 0);
      check({pfx, "_ovr"},   32'(frame_overrun), 0);
`ifdef CTRL_TIMEOUT_EN
      check({pfx, "_to"},    32'(tri_timeout), 0);
`endif
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   initial begin
      repeat (3) @(negedge clk);
      chk_reset("rst");
      check("clr_colr",  32'(clear_colr), 0);
      check("clr_depth", 32'(clear_depth), 4095);
      rstn = 1'b1;

      // n=0: clear then swap
      begin_test();
      num_triangles = 8'd0;
      fs_at(10);
      wait_rel(40);
      check("n0_we_first", we_first, 11);
      check("n0_we_last",  we_last, 26);
      check("n0_we_n",     we_n, 16);
      check("n0_addr_err", addr_err, 0);
      check("n0_sw_n",     sw_n, 1);
      check("n0_sw_cyc",   sw_cyc, 28);
      check("n0_busy_end", busy_last, 28);
      check("n0_st_n",     st_n, 0);

      // n=3 with 5-cycle rasterizer; num_triangles changes after acceptance
      begin_test();
      rast_en = 1'b1;
      num_triangles = 8'd3;
      fs_at(10);
      num_triangles = 8'd7;
      wait_rel(70);
      check("n3_st_n", st_n, 3);
      check("n3_st0",  st_cyc[0], 28);
      check("n3_st1",  st_cyc[1], 34);
      check("n3_st2",  st_cyc[2], 40);
      check("n3_idx0", st_idx[0], 0);
      check("n3_idx1", st_idx[1], 1);
      check("n3_idx2", st_idx[2], 2);
      check("n3_sw_n", sw_n, 1);
      check("n3_sw",   sw_cyc, 46);

      // overruns during CLEAR, WAIT and SWAP
      begin_test();
      num_triangles = 8'd2;
      fs_at(10);
      fs_at(15);
      fs_at(30);
      fs_at(40);
      wait_rel(70);
      check("ov_n",      ov_n, 3);
      check("ov_we_n",   we_n, 16);
      check("ov_st_n",   st_n, 2);
      check("ov_sw_n",   sw_n, 1);
      check("ov_sw",     sw_cyc, 40);
      check("ov_busy",   busy_last, 40);

      // stray tri_done in IDLE, CLEAR and alongside tri_start
      begin_test();
      num_triangles = 8'd2;
      inj_at(5);
      fs_at(10);
      inj_at(15);
      inj_at(28);
      wait_rel(60);
      check("inj_st_n", st_n, 2);
      check("inj_st0",  st_cyc[0], 28);
      check("inj_st1",  st_cyc[1], 34);
      check("inj_idx1", st_idx[1], 1);
      check("inj_sw",   sw_cyc, 40);
      check("inj_sw_n", sw_n, 1);

      // reset mid-clear at address 7, then restart
      begin_test();
      num_triangles = 8'd0;
      fs_at(10);
      wait_rel(17);
      check("mr_addr7", 32'(clear_addr), 7);
      rstn = 1'b0;
      @(negedge clk);
      chk_reset("mr");
      rstn = 1'b1;
      wait_rel(45);
      check("mr_we_n", we_n, 8);
      check("mr_sw_n", sw_n, 0);
      begin_test();
      fs_at(10);
      wait_rel(40);
      check("mr2_we_first", we_first, 11);
      check("mr2_we_n",     we_n, 16);
      check("mr2_addr_err", addr_err, 0);
      check("mr2_sw",       sw_cyc, 28);

`ifdef CTRL_TIMEOUT_EN
      // rasterizer never answers triangle 1
      begin_test();
      drop1 = 1'b1;
      num_triangles = 8'd2;
      fs_at(10);
      wait_rel(80);
      check("to_n",    to_n, 1);
      check("to_cyc",  to_cyc, 55);
      check("to_sw_n", sw_n, 1);
      check("to_sw",   sw_cyc, 55);
      drop1 = 1'b0;
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
